// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared types for the MIPS multiply/divide unit. This package
//            provides the operation and FSM state encodings, plus small
//            helpers that classify an operation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } muldiv_state_t;

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_muldiv_if
// Purpose  : Controller-side bundle of the multiply/divide unit.
// Ports    : master drives enable/start/op/a/b/wr_hi/wr_lo/wdata and
//            observes busy/done/hi/lo/divz; slave is the unit itself.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_muldiv_if #(
  parameter int DBITS = 32
);
  logic             enable;
  logic             start;
  logic [1:0]       op;
  logic [DBITS-1:0] a;
  logic [DBITS-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [DBITS-1:0] wdata;
  logic             busy;
  logic             done;
  logic [DBITS-1:0] hi;
  logic [DBITS-1:0] lo;
  logic             divz;

  modport master (
    output enable, start, op, a, b, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo, divz
  );

  modport slave (
    input  enable, start, op, a, b, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo, divz
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : Combinational iteration slice. It performs BPC unrolled steps on
//            the {acc, q} pair. Multiply mode performs a right-shifting
//            shift-add, and divide mode performs a left-shifting restoring
//            subtract.
// Ports    : i_div  - 1 selects divide, 0 selects multiply
//            i_m    - multiplicand (mul) or divisor (div)
//            i_acc  - upper half of working pair (partial product / remainder)
//            i_q    - lower half (multiplier bits / dividend -> quotient)
//            o_acc  - i_acc after BPC steps
//            o_q    - i_q after BPC steps
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int DBITS = 32,
  parameter int BPC   = 1
) (
  input  wire logic             i_div,
  input  wire logic [DBITS-1:0] i_m,
  input  wire logic [DBITS-1:0] i_acc,
  input  wire logic [DBITS-1:0] i_q,
  output logic      [DBITS-1:0] o_acc,
  output logic      [DBITS-1:0] o_q
);

  logic [DBITS-1:0] w_acc;
  logic [DBITS-1:0] w_q;
  logic [DBITS:0]   w_sum;
  logic [DBITS:0]   w_shl;
  logic [DBITS:0]   w_trial;

  always_comb begin
    w_acc   = i_acc;
    w_q     = i_q;
    w_sum   = '0;
    w_shl   = '0;
    w_trial = '0;
    for (int k = 0; k < BPC; k++) begin
      if (i_div) begin
        // The remainder is always below the divisor, so the shifted value
        // fits in DBITS+1 bits. A borrow out of the trial subtract means
        // "restore".
        w_shl   = {w_acc, w_q[DBITS-1]};
        w_trial = w_shl - {1'b0, i_m};
        w_q     = {w_q[DBITS-2:0], ~w_trial[DBITS]};
        w_acc   = w_trial[DBITS] ? w_shl[DBITS-1:0] : w_trial[DBITS-1:0];
      end else begin
        // The extra sum bit carries into acc. The low sum bit shifts into the
        // freed top of q.
        w_sum = {1'b0, w_acc} + (w_q[0] ? {1'b0, i_m} : {(DBITS+1){1'b0}});
        w_q   = {w_sum[0], w_q[DBITS-1:1]};
        w_acc = w_sum[DBITS:1];
      end
    end
    o_acc = w_acc;
    o_q   = w_q;
  end

endmodule
`default_nettype wire

// File: rtl/mips_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : mips_muldiv
// Purpose  : Iterative MIPS multiply/divide unit. It owns the HI/LO registers
//            and handles mult/multu/div/divu as well as mthi/mtlo. Magnitudes
//            are processed over DBITS/BPC cycles, and the sign is fixed up in
//            a final cycle.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous active-low clear of all state
//            bus   - mips_muldiv_if.slave (enable, start, op, a, b, wr_hi,
//                    wr_lo, wdata in; busy, done, hi, lo, divz out)
// Revision : 1.0 - initial release
// ============================================================================
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int DBITS = 32,  // even, >= 4
  parameter int BPC   = 1    // must divide DBITS
) (
  input wire logic     clk,
  input wire logic     reset,
  mips_muldiv_if.slave bus
);

  localparam int N  = DBITS / BPC;
  localparam int CW = $clog2(N + 1);

  muldiv_state_t    r_state;
  muldiv_op_t       r_op;
  logic [CW-1:0]    r_cnt;
  logic [DBITS-1:0] r_opa;   // |a| for signed ops
  logic [DBITS-1:0] r_opb;   // |b| for signed ops
  logic             r_sa;    // a was negative (signed ops only)
  logic             r_sb;    // b was negative (signed ops only)
  logic [DBITS-1:0] r_acc;
  logic [DBITS-1:0] r_q;
  logic [DBITS-1:0] r_hi;
  logic [DBITS-1:0] r_lo;
  logic             r_done;
  logic             r_divz;

  // Operand capture
  muldiv_op_t       w_start_op;
  logic             w_start_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [DBITS-1:0] w_a_mag;
  logic [DBITS-1:0] w_b_mag;

  assign w_start_op  = muldiv_op_t'(bus.op);
  assign w_start_sgn = op_is_signed(w_start_op);
  assign w_a_neg     = w_start_sgn & bus.a[DBITS-1];
  assign w_b_neg     = w_start_sgn & bus.b[DBITS-1];
  assign w_a_mag     = w_a_neg ? -bus.a : bus.a;
  assign w_b_mag     = w_b_neg ? -bus.b : bus.b;

  // Iteration slice
  logic             w_is_div;
  logic [DBITS-1:0] w_acc_nxt;
  logic [DBITS-1:0] w_q_nxt;

  assign w_is_div = op_is_div(r_op);

  muldiv_step #(
    .DBITS (DBITS),
    .BPC   (BPC)
  ) u_step (
    .i_div (w_is_div),
    .i_m   (w_is_div ? r_opb : r_opa),
    .i_acc (r_acc),
    .i_q   (r_q),
    .o_acc (w_acc_nxt),
    .o_q   (w_q_nxt)
  );

  // Sign fix-up applied in FIX. Because r_sa and r_sb are zero for unsigned
  // ops, no op check is needed here. The most-negative / -1 case falls out
  // naturally, since negating 0x80..0 yields itself.
  logic [2*DBITS-1:0] w_prod;
  logic [2*DBITS-1:0] w_prod_fix;
  logic [DBITS-1:0]   w_quot;
  logic [DBITS-1:0]   w_rem;
  logic [DBITS-1:0]   w_orig_a;
  logic               w_divz;
  logic [DBITS-1:0]   w_res_hi;
  logic [DBITS-1:0]   w_res_lo;

  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
  assign w_quot     = (r_sa ^ r_sb) ? -r_q : r_q;
  assign w_rem      = r_sa ? -r_acc : r_acc;
  assign w_orig_a   = r_sa ? -r_opa : r_opa;
  assign w_divz     = (r_opb == '0);

  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    if (!w_is_div) begin
      {w_res_hi, w_res_lo} = w_prod_fix;
    end else if (w_divz) begin
      w_res_hi = w_orig_a;
      w_res_lo = '1;
    end else begin
      w_res_hi = w_rem;
      w_res_lo = w_quot;
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_op    <= MULT;
      r_cnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_acc   <= '0;
      r_q     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_divz  <= 1'b0;
    end else if (bus.enable) begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            // When start and mthi/mtlo are asserted together, start wins and
            // the register writes are dropped.
            r_op    <= w_start_op;
            r_opa   <= w_a_mag;
            r_opb   <= w_b_mag;
            r_sa    <= w_a_neg;
            r_sb    <= w_b_neg;
            r_acc   <= '0;
            r_q     <= op_is_div(w_start_op) ? w_a_mag : w_b_mag;
            r_cnt   <= CW'(N);
            r_divz  <= 1'b0;
            r_state <= RUN;
          end else begin
            if (bus.wr_hi) r_hi <= bus.wdata;
            if (bus.wr_lo) r_lo <= bus.wdata;
          end
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_divz  <= w_is_div & w_divz;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.divz = r_divz;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_muldiv
// Purpose  : Directed self-checking bench for mips_muldiv. It instantiates
//            two builds: DBITS=32 with BPC=1, and DBITS=32 with BPC=4.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_muldiv;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  mips_muldiv_if #(.DBITS(32)) bus1 ();
  mips_muldiv_if #(.DBITS(32)) bus4 ();

  mips_muldiv #(.DBITS(32), .BPC(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  mips_muldiv #(.DBITS(32), .BPC(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an op on the BPC=1 unit and count busy cycles until it is idle
  // again. The a/b inputs are scrambled after capture to prove they are
  // ignored.
  task automatic run1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int cycles, output int done_at);
    bus1.start = 1'b1;
    bus1.op    = op;
    bus1.a     = a;
    bus1.b     = b;
    tick();
    bus1.start = 1'b0;
    bus1.a     = 32'h5A5A_5A5A;
    bus1.b     = 32'hA5A5_A5A5;
    cycles     = 0;
    done_at    = 0;
    while (bus1.busy && cycles < 200) begin
      cycles++;
      if (bus1.done) done_at = cycles;
      tick();
    end
  endtask

  task automatic run4(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int cycles);
    bus4.start = 1'b1;
    bus4.op    = op;
    bus4.a     = a;
    bus4.b     = b;
    tick();
    bus4.start = 1'b0;
    bus4.a     = 32'h5A5A_5A5A;
    bus4.b     = 32'hA5A5_A5A5;
    cycles     = 0;
    while (bus4.busy && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int done_at;

    bus1.enable = 1'b1; bus1.start = 1'b0; bus1.op = 2'b00;
    bus1.a = '0; bus1.b = '0; bus1.wr_hi = 1'b0; bus1.wr_lo = 1'b0; bus1.wdata = '0;
    bus4.enable = 1'b1; bus4.start = 1'b0; bus4.op = 2'b00;
    bus4.a = '0; bus4.b = '0; bus4.wr_hi = 1'b0; bus4.wr_lo = 1'b0; bus4.wdata = '0;

    tick();
    tick();
    check_eq("reset busy", bus1.busy, 0);
    check_eq("reset done", bus1.done, 0);
    check_eq("reset hi",   bus1.hi,   0);
    check_eq("reset lo",   bus1.lo,   0);
    check_eq("reset divz", bus1.divz, 0);
    reset = 1'b1;
    tick();

    // multu max*max: 34 busy cycles, with done in the last one
    run1(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, done_at);
    check_eq("multu busy cycles", cyc, 34);
    check_eq("multu done cycle",  done_at, 34);
    check_eq("multu hi", bus1.hi, 64'hFFFF_FFFE);
    check_eq("multu lo", bus1.lo, 64'h0000_0001);
    check_eq("done low after", bus1.done, 0);

    // signed multiply and divide
    run1(2'b00, 32'hFFFF_FFFD, 32'd7, cyc, done_at);
    check_eq("mult hi", bus1.hi, 64'hFFFF_FFFF);
    check_eq("mult lo", bus1.lo, 64'hFFFF_FFEB);
    run1(2'b10, 32'hFFFF_FFF9, 32'd2, cyc, done_at);
    check_eq("div lo", bus1.lo, 64'hFFFF_FFFD);
    check_eq("div hi", bus1.hi, 64'hFFFF_FFFF);

    // divide by zero, then signed overflow
    run1(2'b11, 32'd100, 32'd0, cyc, done_at);
    check_eq("divz cycles", cyc, 34);
    check_eq("divz lo",   bus1.lo,   64'hFFFF_FFFF);
    check_eq("divz hi",   bus1.hi,   64'd100);
    check_eq("divz flag", bus1.divz, 1);
    run1(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, done_at);
    check_eq("ovf lo",   bus1.lo,   64'h8000_0000);
    check_eq("ovf hi",   bus1.hi,   64'h0);
    check_eq("ovf divz", bus1.divz, 0);

    // start in RUN cycle 5 is ignored, and wr_lo while busy is ignored
    bus1.start = 1'b1; bus1.op = 2'b01; bus1.a = 32'd6; bus1.b = 32'd7;
    tick();
    bus1.start = 1'b0;
    cyc = 1;
    repeat (4) begin tick(); cyc++; end
    bus1.start = 1'b1; bus1.op = 2'b11; bus1.a = 32'd1; bus1.b = 32'd1;
    tick(); cyc++;
    bus1.start = 1'b0;
    check_eq("busy after stray start", bus1.busy, 1);
    repeat (2) begin tick(); cyc++; end
    bus1.wr_lo = 1'b1; bus1.wdata = 32'h5555_5555;
    tick(); cyc++;
    bus1.wr_lo = 1'b0;
    check_eq("wr_lo while busy", bus1.lo, 64'h8000_0000);
    while (bus1.busy && cyc < 200) begin cyc++; tick(); end
    check_eq("stray start length", cyc, 35);
    check_eq("stray start lo", bus1.lo, 64'd42);
    check_eq("stray start hi", bus1.hi, 64'd0);

    // mthi, then both writes together
    bus1.wr_hi = 1'b1; bus1.wdata = 32'h0000_1234;
    tick();
    bus1.wr_hi = 1'b0;
    check_eq("mthi hi", bus1.hi, 64'h1234);
    check_eq("mthi lo kept", bus1.lo, 64'd42);
    bus1.wr_hi = 1'b1; bus1.wr_lo = 1'b1; bus1.wdata = 32'd77;
    tick();
    bus1.wr_hi = 1'b0; bus1.wr_lo = 1'b0;
    check_eq("both hi", bus1.hi, 64'd77);
    check_eq("both lo", bus1.lo, 64'd77);

    // start + wr_lo together: the write is dropped
    bus1.start = 1'b1; bus1.op = 2'b01; bus1.a = 32'd2; bus1.b = 32'd3;
    bus1.wr_lo = 1'b1; bus1.wdata = 32'h0000_ABCD;
    tick();
    bus1.start = 1'b0; bus1.wr_lo = 1'b0;
    check_eq("start+wr_lo lo", bus1.lo, 64'd77);
    check_eq("start+wr_lo busy", bus1.busy, 1);
    cyc = 0;
    while (bus1.busy && cyc < 200) begin cyc++; tick(); end
    check_eq("start+wr_lo result lo", bus1.lo, 64'd6);
    check_eq("start+wr_lo result hi", bus1.hi, 64'd0);

    // 10 disabled cycles mid-RUN delay done by exactly 10
    bus1.start = 1'b1; bus1.op = 2'b01; bus1.a = 32'd1000; bus1.b = 32'd1000;
    tick();
    bus1.start = 1'b0;
    cyc = 0;
    done_at = 0;
    while (bus1.busy && cyc < 300) begin
      cyc++;
      if (bus1.done) done_at = cyc;
      if (cyc == 10) check_eq("stall lo held", bus1.lo, 64'd6);
      bus1.enable = (cyc >= 4 && cyc < 14) ? 1'b0 : 1'b1;
      tick();
    end
    bus1.enable = 1'b1;
    check_eq("stall busy cycles", cyc, 44);
    check_eq("stall done cycle",  done_at, 44);
    check_eq("stall lo", bus1.lo, 64'h000F_4240);
    check_eq("stall hi", bus1.hi, 64'd0);

    // asynchronous reset mid-RUN
    bus1.start = 1'b1; bus1.op = 2'b01; bus1.a = 32'd5; bus1.b = 32'd5;
    tick();
    bus1.start = 1'b0;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    check_eq("async rst busy", bus1.busy, 0);
    check_eq("async rst hi",   bus1.hi,   0);
    check_eq("async rst lo",   bus1.lo,   0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("post rst idle", bus1.busy, 0);

    // BPC=4 build
    run4(2'b11, 32'hDEAD_BEEF, 32'h0000_0010, cyc);
    check_eq("bpc4 divu cycles", cyc, 10);
    check_eq("bpc4 divu lo", bus4.lo, 64'h0DEA_DBEE);
    check_eq("bpc4 divu hi", bus4.hi, 64'hF);
    run4(2'b10, 32'hFFFF_FFF9, 32'd2, cyc);
    check_eq("bpc4 div lo", bus4.lo, 64'hFFFF_FFFD);
    check_eq("bpc4 div hi", bus4.hi, 64'hFFFF_FFFF);
    run4(2'b00, 32'hFFFF_FFFD, 32'd7, cyc);
    check_eq("bpc4 mult hi", bus4.hi, 64'hFFFF_FFFF);
    check_eq("bpc4 mult lo", bus4.lo, 64'hFFFF_FFEB);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
Iterative multiply/divide unit for the MIPS core. It implements mult, multu, div, divu, mfhi/mflo readout and mthi/mtlo writes, and drives a busy signal the controller uses to stall. Width and throughput are parametrised; the unit sits beside the datapath ALU and owns the HI/LO registers.

Parameters:
Dbits, 32, operand/HI/LO width; must be even and at least 4.
BPC, 1, bits retired per iteration cycle; must divide Dbits.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low; 0 clears all state.
enable  input  1  global advance; 0 freezes all registers (no state change, outputs hold).
start  input  1  launch operation; sampled only in IDLE with enable=1.
op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
a  input  Dbits  rs operand (multiplicand / dividend).
b  input  Dbits  rt operand (multiplier / divisor).
wr_hi  input  1  mthi strobe.
wr_lo  input  1  mtlo strobe.
wdata  input  Dbits  mthi/mtlo data.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse; HI/LO hold the new result.
hi  output  Dbits  HI register.
lo  output  Dbits  LO register.
divz  output  1  last division had b==0; cleared by the next accepted start.

Behaviour:
- Reset (reset=0, any time, including mid-operation): state=IDLE, hi=0, lo=0, divz=0, busy=0, done=0; partial results discarded.
- Define N = Dbits/BPC.
- FSM: IDLE -> RUN on start&enable; RUN holds N enabled cycles; then FIX for 1 cycle; then DONE for 1 cycle; then IDLE.
- Cycle accounting at enable=1, with start sampled at edge 0: busy=1 for the N+2 cycles following edge 0. HI/LO are written at the edge leaving FIX. done=1 for the single DONE cycle. A new start can be accepted at the edge leaving DONE? No: start is accepted only in IDLE, so the earliest next start is the cycle after DONE.
- enable=0 stalls the FSM and all datapath registers in place; latency is counted in enabled cycles only.
- Operand capture at start:
  - Signed ops store |a|, |b| plus the sign bits.
  - Unsigned ops store the operands as-is.
  - The a/b inputs are ignored after capture.
- Multiply: unsigned shift-add, BPC bits per cycle, producing a 2*Dbits product. In FIX, the product is negated if the op is signed and the signs differ. Result: hi=upper Dbits, lo=lower Dbits.
- Divide: restoring division, BPC quotient bits per cycle. In FIX:
  - the quotient is negated if the op is signed and the signs differ;
  - the remainder is negated if the op is signed and a was negative.
  - Result: lo=quotient, hi=remainder.
- Divide by zero: runs the full latency. Result: lo=all ones, hi=original a, divz=1.
- Signed overflow (a = -2^(Dbits-1), b = -1): lo=0x80..0, hi=0, divz=0. This falls out of the absolute-value datapath with no special case.
- mthi/mtlo:
  - Honoured only in IDLE with enable=1; hi/lo update at that edge.
  - Ignored while busy (the controller must stall).
  - wr_hi and wr_lo together write both registers.
  - start together with wr_hi or wr_lo in IDLE: start wins and the writes are dropped.
- start while busy: ignored; no queueing.
- hi/lo hold their old values during RUN/FIX. They change only at the FIX->DONE edge, via mthi/mtlo, or on reset.

Decomposition:
- Shared package mips_pkg: muldiv_op_t enum (MULT, MULTU, DIV, DIVU) and muldiv_state_t enum (IDLE, RUN, FIX, DONE).
- Iteration counter width is derived locally as $clog2(N+1).
- One sub-module, muldiv_step: combinational, parametrised by Dbits and BPC. It performs BPC unrolled shift-add or restore-subtract steps on the {acc, q} pair and is selected by a mul/div mode bit.

Test Plan:
1. multu a=0xFFFFFFFF b=0xFFFFFFFF (Dbits=32, BPC=1) -> busy=1 for 34 cycles; done pulses on cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
2. mult a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. div a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. divu a=100 b=0 -> lo=0xFFFFFFFF, hi=100, divz=1. Then div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, divz=0.
4. Contention cases:
   - start pulsed at RUN cycle 5 -> ignored; the result equals the original op.
   - wr_lo during busy -> lo unchanged.
   - In IDLE, wr_hi=1 with wdata=0x1234 -> hi=0x1234.
   - start plus wr_lo in the same cycle -> the write is dropped.
5. Stall and reset:
   - enable=0 for 10 cycles mid-RUN -> done is delayed by exactly 10 cycles; the result is correct.
   - reset=0 mid-RUN -> busy drops immediately with no clock edge; hi=lo=0.
6. BPC=4 build, divu 0xDEADBEEF/0x10 -> busy for 10 cycles; lo=0x0DEADBEE, hi=0xF.
